// File: rtl/mealy_101x_seq_det_over.sv
// mealy_101x_seq_det_over: overlapping Mealy detector for serial pattern 1,0,1,X.
// OP is high while CS holds "101", so the X bit is flagged in its own cycle.
module mealy_101x_seq_det_over (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       In,
   output logic       OP,
   output logic [1:0] CS,
   output logic [1:0] NS
);
   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10,
      S3 = 2'b11
   } state_t;
   state_t r_cs;
   state_t w_ns;
   logic   w_op;
   always_ff @(posedge Clk) begin
      if (Rst) r_cs <= S0;
      else     r_cs <= w_ns;
   end
   // S3 keeps the longest reusable suffix: "1011" -> S1, "1010" -> S2
   always_comb begin
      w_ns = S0;
      if (!Rst) begin
         case (r_cs)
            S0:      w_ns = In ? S1 : S0;
            S1:      w_ns = In ? S1 : S2;
            S2:      w_ns = In ? S3 : S0;
            S3:      w_ns = In ? S1 : S2;
            default: w_ns = S0;
         endcase
      end
   end
   always_comb begin
      w_op = 1'b0;
      if (!Rst) begin
         case (r_cs)
            S3:      w_op = 1'b1;
            default: w_op = 1'b0;
         endcase
      end
   end
   assign OP = w_op;
   assign CS = r_cs;
   assign NS = w_ns;
endmodule

// File: tb/tb_mealy_101x_seq_det_over.sv
// tb_mealy_101x_seq_det_over: directed and random checks against a window-based suffix model.
module tb_mealy_101x_seq_det_over;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       In  = 1'b0;
   logic       OP;
   logic [1:0] CS;
   logic [1:0] NS;
   int         checks   = 0;
   int         failures = 0;
   logic [2:0] win = 3'b000;
   int         cnt = 0;

   mealy_101x_seq_det_over dut (
      .Clk(Clk),
      .Rst(Rst),
      .In (In),
      .OP (OP),
      .CS (CS),
      .NS (NS)
   );

   always #5 Clk = ~Clk;

   // Longest suffix of the bits seen since reset that is a prefix of "101"
   function automatic logic [1:0] match_len(input logic [2:0] w, input int n);
      if (n >= 3 && w == 3'b101) return 2'd3;
      if (n >= 2 && w[1:0] == 2'b10) return 2'd2;
      if (n >= 1 && w[0]) return 2'd1;
      return 2'd0;
   endfunction

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst_v, input logic in_v, input string tag);
      logic [1:0] e_ns;
      logic       e_op;
      @(negedge Clk);
      Rst = rst_v;
      In  = in_v;
      #1;
      e_ns = rst_v ? 2'd0 : match_len({win[1:0], in_v}, (cnt >= 3) ? 3 : cnt + 1);
      e_op = !rst_v && (match_len(win, cnt) == 2'd3);
      chk({tag, ".NS"}, NS, e_ns);
      chk({tag, ".OP"}, {1'b0, OP}, {1'b0, e_op});
      @(posedge Clk);
      if (rst_v) begin
         win = 3'b000;
         cnt = 0;
      end else begin
         win = {win[1:0], in_v};
         cnt = (cnt >= 3) ? 3 : cnt + 1;
      end
      #1;
      chk({tag, ".CS"}, CS, match_len(win, cnt));
   endtask

   task automatic seq(input logic [7:0] bits, input int len, input string tag);
      for (int i = len - 1; i >= 0; i--) step(1'b0, bits[i], tag);
   endtask

   task automatic rst_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b1, i[0], "reset");
   endtask

   initial begin
      rst_cycles(2);
      step(1'b0, 1'b0, "idle");
      chk("idle_cs_literal", CS, 2'b00);
      seq(8'b1010, 4, "x0");
      chk("x0_cs_literal", CS, 2'b10);
      rst_cycles(1);
      seq(8'b1011, 4, "x1");
      chk("x1_cs_literal", CS, 2'b01);
      seq(8'b010, 3, "x1_tail");
      rst_cycles(1);
      seq(8'b10101010, 8, "overlap");
      rst_cycles(1);
      seq(8'b1100100, 7, "nomatch");
      chk("nomatch_cs_literal", CS, 2'b00);
      rst_cycles(1);
      seq(8'b10, 2, "mid");
      step(1'b1, 1'b1, "mid_rst");
      chk("mid_rst_cs_literal", CS, 2'b00);
      step(1'b0, 1'b1, "mid_after");
      chk("mid_after_cs_literal", CS, 2'b01);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0) ^ i[0], "rand");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
